square_restorer: RTL

Iterative inverse of the non-restoring square-root extractor: it takes an integer root `q` and remainder `r` and rebuilds the radicand `N = q*q + r`, one shift-add step per clock. It also flags pairs that the extractor could never produce (`r > 2q`). It sits after the square-root pipeline as a self-check / reconstruction stage. Input and output use independent valid/ready handshakes.

---
 rtl/square_restorer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/square_restorer.sv
// Rebuilds a radicand N = q*q + r from a square-root result, one shift-add per clock,
// and flags root/remainder pairs that a square-root extractor cannot produce (r > 2q).
module square_restorer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     root,
    input  logic [WIDTH:0]       remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   radicand,
    output logic                 err,
    output logic                 busy
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_acc_next;
    logic [ACC_W-1:0]     w_addend;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 w_inconsistent;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_radicand;
    logic                 r_err_out;

    // Consistency test: any r above 2q also covers every case that would carry out of 2*WIDTH bits.
    always_comb begin
        w_inconsistent = 1'b0;
        if (remainder > {root, 1'b0}) begin
            w_inconsistent = 1'b1;
        end else begin
            w_inconsistent = 1'b0;
        end
    end

    // Next-state decode; inputs are only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // One shift-add step: add the multiplicand weighted by the current bit position.
    always_comb begin
        w_addend   = ACC_W'(r_mcand) << r_cnt;
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + w_addend;
        end else begin
            w_acc_next = r_acc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load operands on acceptance, then step the multiplier for WIDTH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= {ACC_W{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= ACC_W'(remainder);
                        r_mcand  <= root;
                        r_mplier <= root;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_err    <= w_inconsistent;
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_acc    <= r_acc;
                end
            endcase
        end
    end

    // Handshake and result registers, derived from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_radicand  <= {(2*WIDTH){1'b0}};
            r_err_out   <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            r_busy      <= (w_state_next != ST_IDLE);
            if ((r_state == ST_CALC) && (w_state_next == ST_DONE)) begin
                r_radicand <= w_acc_next[2*WIDTH-1:0];
                r_err_out  <= r_err;
            end else if (w_state_next == ST_DONE) begin
                r_radicand <= r_radicand;
                r_err_out  <= r_err_out;
            end else begin
                r_radicand <= {(2*WIDTH){1'b0}};
                r_err_out  <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign radicand  = r_radicand;
    assign err       = r_err_out;

endmodule
